// File: rtl/addr_map_cfg.sv
// -----------------------------------------------------------------------------
// addr_map_cfg
//
// Loads address-decoder rules one at a time into a shadow map. On a commit
// request it checks every shadow rule in turn, one rule per cycle. If all
// rules pass, the whole shadow map is copied into the active map in a single
// step. A decoder reading addr_map_o therefore only ever sees a complete map
// that has passed the checks.
//
// Optional build macro:
//   ADDR_MAP_CFG_OVERLAP_CHECK_EN - also reject a map in which a rule overlaps
//                                   any later rule (error code 3). When the
//                                   macro is undefined, overlaps are allowed
//                                   and the decoder resolves them by priority.
//
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   cfg_valid_i       rule write request
//   cfg_ready_o       write accepted (idle only)
//   cfg_sel_i         shadow slot to write; an out-of-range slot drops the write
//   cfg_rule_i        rule data
//   commit_valid_i    commit request
//   commit_ready_o    commit accepted (idle only)
//   commit_done_o     one-cycle pulse in the first cycle the new map is active
//   commit_err_o      one-cycle pulse when a commit is rejected
//   err_code_o        0 none, 1 start>=end, 2 idx out of range, 3 overlap
//   err_rule_o        first failing rule, held with err_code_o
//   addr_map_o        active map, slot i at bits [i*$bits(rule_t) +: $bits(rule_t)]
//   map_valid_o       high once any commit has succeeded
//
// NoRules must be greater than 0.
// -----------------------------------------------------------------------------
module addr_map_cfg #(
   parameter int unsigned NoRules   = 32'd4,
   parameter int unsigned NoIndices = 32'd4,
   parameter type         addr_t    = logic,
   // Same layout as the decoder rule: {idx[31:0], start_addr, end_addr}
   parameter type         rule_t    = logic [32+2*$bits(addr_t)-1:0],
   parameter int unsigned SelWidth  = (NoRules > 32'd1) ? $clog2(NoRules) : 32'd1,
   parameter type         sel_t     = logic [SelWidth-1:0]
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           cfg_valid_i,
   output logic                           cfg_ready_o,
   input  logic [SelWidth-1:0]            cfg_sel_i,
   input  logic [$bits(rule_t)-1:0]       cfg_rule_i,
   input  logic                           commit_valid_i,
   output logic                           commit_ready_o,
   output logic                           commit_done_o,
   output logic                           commit_err_o,
   output logic [1:0]                     err_code_o,
   output logic [SelWidth-1:0]            err_rule_o,
   output logic [NoRules*$bits(rule_t)-1:0] addr_map_o,
   output logic                           map_valid_o
);

   localparam int unsigned RuleW = $bits(rule_t);
   localparam logic [SelWidth-1:0] LastSel = SelWidth'(NoRules - 32'd1);

   // Field view of a rule. It does not depend on the exact rule_t type
   // supplied by the user.
   typedef struct packed {
      logic [31:0] idx;
      addr_t       start_addr;
      addr_t       end_addr;
   } rule_view_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_COMMIT,
      ST_ABORT
   } state_t;

   state_t                     state_reg, state_next;
   logic [SelWidth-1:0]        cnt_reg, cnt_next;
   logic [1:0]                 err_code_reg, err_code_next;
   logic [SelWidth-1:0]        err_rule_reg, err_rule_next;
   logic                       done_reg, done_next;
   logic                       err_reg, err_next;
   logic                       map_valid_reg;
   logic [NoRules*RuleW-1:0]   active_reg;
   logic                       ready_en_reg;
   logic                       load_active;

   logic                       idle;
   logic                       cfg_fire;
   logic                       commit_fire;
   rule_view_t                 slot_view [NoRules];
   logic [NoRules*RuleW-1:0]   shadow_flat;
   rule_view_t                 cur_rule;
   logic                       overlap_hit;
   logic [1:0]                 fail_code;

   // Ready is held low during reset and for the first cycle after release.
   // This keeps every output at 0 while reset is asserted.
   assign idle        = ready_en_reg && (state_reg == ST_IDLE);
   assign cfg_fire    = cfg_valid_i && idle;
   assign commit_fire = commit_valid_i && idle;

   // Shadow slots. A write to a slot index that has no slot matches no
   // slot, so the write is dropped.
   for (genvar gi = 0; gi < NoRules; gi++) begin : g_slot
      logic [RuleW-1:0] slot_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            slot_reg <= '0;
         end else if (cfg_fire && (cfg_sel_i == SelWidth'(gi))) begin
            slot_reg <= cfg_rule_i;
         end
      end

      assign slot_view[gi]                 = slot_reg;
      assign shadow_flat[gi*RuleW +: RuleW] = slot_reg;
   end

   // Select the rule currently under check.
   always_comb begin
      cur_rule = '0;
      for (int i = 0; i < int'(NoRules); i++) begin
         if (cnt_reg == SelWidth'(i)) begin
            cur_rule = slot_view[i];
         end
      end
   end

`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
   // Compare the current rule against every later rule in the same cycle.
   // Earlier rules were already compared against this one while they were
   // being checked.
   logic [NoRules-1:0] overlap_vec;

   for (genvar gi = 0; gi < NoRules; gi++) begin : g_overlap
      assign overlap_vec[gi] = (SelWidth'(gi) > cnt_reg) &&
                               (slot_view[gi].start_addr < cur_rule.end_addr) &&
                               (slot_view[gi].end_addr   > cur_rule.start_addr);
   end

   assign overlap_hit = |overlap_vec;
`else
   assign overlap_hit = 1'b0;
`endif

   // Failure priority: empty or inverted range, then bad index, then overlap.
   always_comb begin
      fail_code = 2'd0;
      if (cur_rule.start_addr >= cur_rule.end_addr) begin
         fail_code = 2'd1;
      end else if (cur_rule.idx >= NoIndices) begin
         fail_code = 2'd2;
      end else if (overlap_hit) begin
         fail_code = 2'd3;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      err_code_next = err_code_reg;
      err_rule_next = err_rule_reg;
      done_next     = 1'b0;
      err_next      = 1'b0;
      load_active   = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (commit_fire) begin
               err_code_next = 2'd0;
               err_rule_next = '0;
               cnt_next      = '0;
               state_next    = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (fail_code != 2'd0) begin
               err_code_next = fail_code;
               err_rule_next = cnt_reg;
               err_next      = 1'b1;
               state_next    = ST_ABORT;
            end else if (cnt_reg == LastSel) begin
               // The copy happens on the same edge that raises done. This
               // way the pulse marks the first cycle of the new map.
               load_active = 1'b1;
               done_next   = 1'b1;
               state_next  = ST_COMMIT;
            end else begin
               cnt_next = cnt_reg + SelWidth'(1);
            end
         end
         ST_COMMIT: state_next = ST_IDLE;
         ST_ABORT:  state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         err_code_reg  <= 2'd0;
         err_rule_reg  <= '0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         map_valid_reg <= 1'b0;
         active_reg    <= '0;
         ready_en_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         err_code_reg <= err_code_next;
         err_rule_reg <= err_rule_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         ready_en_reg <= 1'b1;
         if (load_active) begin
            active_reg    <= shadow_flat;
            map_valid_reg <= 1'b1;
         end
      end
   end

   assign cfg_ready_o    = idle;
   assign commit_ready_o = idle;
   assign commit_done_o  = done_reg;
   assign commit_err_o   = err_reg;
   assign err_code_o     = err_code_reg;
   assign err_rule_o     = err_rule_reg;
   assign addr_map_o     = active_reg;
   assign map_valid_o    = map_valid_reg;

endmodule

// File: tb/tb_addr_map_cfg.sv
// -----------------------------------------------------------------------------
// tb_addr_map_cfg
//
// Self-checking bench for addr_map_cfg with four rules, four legal indices
// and 32-bit addresses. A reference model holds the shadow map and the
// active map as arrays. It finds the expected outcome of each commit by
// walking the rules in order.
// -----------------------------------------------------------------------------
module tb_addr_map_cfg;

   localparam int NR = 4;
   localparam int NI = 4;

   typedef logic [31:0] addr_t;
   typedef struct packed {
      int unsigned idx;
      addr_t       start_addr;
      addr_t       end_addr;
   } rule_t;

   localparam int RW = $bits(rule_t);
   localparam int MW = NR * RW;

`ifdef ADDR_MAP_CFG_OVERLAP_CHECK_EN
   localparam bit OvlEn = 1'b1;
`else
   localparam bit OvlEn = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_valid = 1'b0;
   logic          cfg_ready;
   logic [1:0]    cfg_sel = '0;
   rule_t         cfg_rule = '0;
   logic          commit_valid = 1'b0;
   logic          commit_ready;
   logic          commit_done;
   logic          commit_err;
   logic [1:0]    err_code;
   logic [1:0]    err_rule;
   logic [MW-1:0] addr_map;
   logic          map_valid;

   int checks = 0;
   int failures = 0;

   rule_t shadow_m [NR];
   rule_t active_m [NR];
   bit    map_valid_m = 1'b0;

   always #5 clk = ~clk;

   addr_map_cfg #(
      .NoRules   (32'd4),
      .NoIndices (32'd4),
      .addr_t    (addr_t),
      .rule_t    (rule_t)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .cfg_valid_i    (cfg_valid),
      .cfg_ready_o    (cfg_ready),
      .cfg_sel_i      (cfg_sel),
      .cfg_rule_i     (cfg_rule),
      .commit_valid_i (commit_valid),
      .commit_ready_o (commit_ready),
      .commit_done_o  (commit_done),
      .commit_err_o   (commit_err),
      .err_code_o     (err_code),
      .err_rule_o     (err_rule),
      .addr_map_o     (addr_map),
      .map_valid_o    (map_valid)
   );

   // ---------------- reference model ----------------
   function automatic rule_t mk_rule(int unsigned idx, int unsigned s, int unsigned e);
      rule_t r;
      r.idx = idx;
      r.start_addr = s;
      r.end_addr = e;
      return r;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NR; i++) begin
         shadow_m[i] = '0;
         active_m[i] = '0;
      end
      map_valid_m = 1'b0;
   endfunction

   // Outcome of a commit of the current shadow map: code 0 means accepted.
   function automatic void model_result(output int code, output int bad);
      code = 0;
      bad = 0;
      for (int k = 0; k < NR; k++) begin
         if (shadow_m[k].start_addr >= shadow_m[k].end_addr) begin
            code = 1; bad = k; return;
         end
         if (shadow_m[k].idx >= NI) begin
            code = 2; bad = k; return;
         end
         if (OvlEn) begin
            for (int j = k + 1; j < NR; j++) begin
               if (shadow_m[j].start_addr < shadow_m[k].end_addr &&
                   shadow_m[j].end_addr > shadow_m[k].start_addr) begin
                  code = 3; bad = k; return;
               end
            end
         end
      end
   endfunction

   function automatic void model_apply(int code);
      if (code == 0) begin
         for (int i = 0; i < NR; i++) active_m[i] = shadow_m[i];
         map_valid_m = 1'b1;
      end
   endfunction

   function automatic logic [MW-1:0] exp_map();
      logic [MW-1:0] m;
      m = '0;
      for (int i = 0; i < NR; i++) m[i*RW +: RW] = active_m[i];
      return m;
   endfunction

   // Rule for a slot, most of the time valid and disjoint. Some of the time
   // it is given an empty or inverted range, a bad index, or an end that
   // spills into the next slot's region.
   function automatic rule_t rand_rule(int slot);
      int unsigned base, s, e, idx, pick;
      base = slot * 32'h1000;
      s    = base + ($urandom_range(0, 15) << 4);
      e    = base + 32'h800 + ($urandom_range(0, 15) << 4);
      idx  = $urandom_range(0, NI - 1);
      pick = $urandom_range(0, 9);
      if (pick == 0) e = s;
      else if (pick == 1) begin e = s; s = s + 32'h10; end
      else if (pick == 2) idx = $urandom_range(NI, 32'hFFFF_FFFF);
      else if (pick == 3) e = base + 32'h1800;
      return mk_rule(idx, s, e);
   endfunction

   // ---------------- drivers ----------------
   task automatic write_rule(input logic [1:0] sel, input rule_t r);
      int guard;
      guard = 0;
      cfg_valid = 1'b1;
      cfg_sel   = sel;
      cfg_rule  = r;
      while (cfg_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 50) begin
         checks++; failures++;
         $display("FAIL write_timeout: cfg_ready stayed %b for %0d cycles, required 1", cfg_ready, guard);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      shadow_m[sel] = r;
   endtask

   // Issues one commit, optionally with a write in the same cycle. It then
   // watches the block until it is idle again. Cycle numbers count from 1,
   // which is the first cycle after the commit is accepted.
   task automatic run_commit(input bit with_wr, input logic [1:0] wsel, input rule_t wrule,
                             output int done_cyc, output int err_cyc, output int pulses,
                             output bit early, output int waited, output bit timeout);
      logic [MW-1:0] map_before;
      done_cyc = -1; err_cyc = -1; pulses = 0; early = 1'b0; waited = 0; timeout = 1'b0;
      while (commit_ready !== 1'b1 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (waited >= 50) begin
         timeout = 1'b1;
         return;
      end
      map_before = addr_map;
      commit_valid = 1'b1;
      if (with_wr) begin
         cfg_valid = 1'b1; cfg_sel = wsel; cfg_rule = wrule;
      end
      @(posedge clk); #1;
      commit_valid = 1'b0;
      cfg_valid = 1'b0;
      if (with_wr) shadow_m[wsel] = wrule;
      for (int n = 1; n <= 40; n++) begin
         if (commit_done === 1'b1) begin pulses++; if (done_cyc < 0) done_cyc = n; end
         if (commit_err === 1'b1) begin pulses++; if (err_cyc < 0) err_cyc = n; end
         if (done_cyc < 0 && addr_map !== map_before) early = 1'b1;
         if (commit_ready === 1'b1) return;
         @(posedge clk); #1;
      end
      timeout = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cfg_ready, commit_ready, commit_done, commit_err} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: ready/ready/done/err=%b required 0000",
                  {cfg_ready, commit_ready, commit_done, commit_err});
      end
      checks++;
      if ({err_code, err_rule, map_valid} !== 5'd0 || addr_map !== '0) begin
         failures++;
         $display("FAIL reset_state: code=%0d rule=%0d valid=%b map=%h required all 0",
                  err_code, err_rule, map_valid, addr_map);
      end
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      checks++;
      if ({cfg_ready, commit_ready} !== 2'b11) begin
         failures++;
         $display("FAIL reset_release_ready: got %b required 11", {cfg_ready, commit_ready});
      end
      $display("test_reset: done");
   endtask

   task automatic test_disjoint();
      int dc, ec, pc, wt; bit early, to;
      for (int i = 0; i < NR; i++)
         write_rule(2'(i), mk_rule($urandom_range(0, NI - 1), i * 32'h1000, (i + 1) * 32'h1000));
      run_commit(1'b0, 2'd0, '0, dc, ec, pc, early, wt, to);
      for (int i = 0; i < NR; i++) active_m[i] = shadow_m[i];
      map_valid_m = 1'b1;
      checks++;
      if (to || dc != 5 || ec != -1 || pc != 1 || early) begin
         failures++;
         $display("FAIL disjoint_timing: to=%0b done@%0d err@%0d pulses=%0d early=%0b required done@5 no err 1 pulse",
                  to, dc, ec, pc, early);
      end
      checks++;
      if (addr_map !== exp_map() || map_valid !== 1'b1 || err_code !== 2'd0) begin
         failures++;
         $display("FAIL disjoint_map: map=%h valid=%b code=%0d required map=%h valid=1 code=0",
                  addr_map, map_valid, err_code, exp_map());
      end
      $display("test_disjoint: commit done@%0d", dc);
   endtask

   task automatic test_bad_idx();
      int dc, ec, pc, wt; bit early, to;
      write_rule(2'd2, mk_rule(5, 32'h2000, 32'h3000));
      run_commit(1'b0, 2'd0, '0, dc, ec, pc, early, wt, to);
      checks++;
      if (to || ec != 4 || dc != -1 || pc != 1) begin
         failures++;
         $display("FAIL bad_idx_timing: to=%0b err@%0d done@%0d pulses=%0d required err@4 only", to, ec, dc, pc);
      end
      checks++;
      if (err_code !== 2'd2 || err_rule !== 2'd2) begin
         failures++;
         $display("FAIL bad_idx_code: code=%0d rule=%0d required code=2 rule=2", err_code, err_rule);
      end
      checks++;
      if (addr_map !== exp_map() || map_valid !== 1'b1 || early) begin
         failures++;
         $display("FAIL bad_idx_map: map=%h valid=%b required map=%h valid=1", addr_map, map_valid, exp_map());
      end
      write_rule(2'd2, mk_rule(2, 32'h2000, 32'h3000));
      $display("test_bad_idx: err@%0d code=%0d rule=%0d", ec, err_code, err_rule);
   endtask

   task automatic test_bad_range();
      int dc, ec, pc, wt; bit early, to;
      write_rule(2'd1, mk_rule(1, 32'h1000, 32'h1000));
      write_rule(2'd3, mk_rule(3, 32'h4000, 32'h3000));
      run_commit(1'b0, 2'd0, '0, dc, ec, pc, early, wt, to);
      checks++;
      if (to || ec != 3 || err_code !== 2'd1 || err_rule !== 2'd1 || pc != 1) begin
         failures++;
         $display("FAIL bad_range: to=%0b err@%0d code=%0d rule=%0d pulses=%0d required err@3 code=1 rule=1",
                  to, ec, err_code, err_rule, pc);
      end
      checks++;
      if (addr_map !== exp_map()) begin
         failures++;
         $display("FAIL bad_range_map: map=%h required %h", addr_map, exp_map());
      end
      write_rule(2'd1, mk_rule(1, 32'h1000, 32'h2000));
      write_rule(2'd3, mk_rule(3, 32'h3000, 32'h4000));
      $display("test_bad_range: err@%0d code=%0d rule=%0d", ec, err_code, err_rule);
   endtask

   task automatic test_overlap();
      int dc, ec, pc, wt; bit early, to;
      write_rule(2'd0, mk_rule(0, 32'h0000, 32'h2000));
      write_rule(2'd1, mk_rule(1, 32'h1000, 32'h3000));
      run_commit(1'b0, 2'd0, '0, dc, ec, pc, early, wt, to);
      if (OvlEn) begin
         checks++;
         if (to || ec != 2 || dc != -1 || err_code !== 2'd3 || err_rule !== 2'd0) begin
            failures++;
            $display("FAIL overlap_on: to=%0b err@%0d done@%0d code=%0d rule=%0d required err@2 code=3 rule=0",
                     to, ec, dc, err_code, err_rule);
         end
      end else begin
         model_apply(0);
         checks++;
         if (to || dc != 5 || ec != -1 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL overlap_off: to=%0b done@%0d err@%0d code=%0d required done@5 code=0",
                     to, dc, ec, err_code);
         end
      end
      checks++;
      if (addr_map !== exp_map()) begin
         failures++;
         $display("FAIL overlap_map: map=%h required %h", addr_map, exp_map());
      end
      write_rule(2'd0, mk_rule(0, 32'h0000, 32'h1000));
      write_rule(2'd1, mk_rule(1, 32'h1000, 32'h2000));
      $display("test_overlap: overlap_check=%0b done@%0d err@%0d code=%0d", OvlEn, dc, ec, err_code);
   endtask

   task automatic test_same_cycle_write();
      int dc, ec, pc, wt; bit early, to;
      rule_t r;
      r = mk_rule(1, 32'h2000, 32'h2800);
      run_commit(1'b1, 2'd2, r, dc, ec, pc, early, wt, to);
      model_apply(0);
      checks++;
      if (to || dc != 5 || ec != -1) begin
         failures++;
         $display("FAIL same_cycle_timing: to=%0b done@%0d err@%0d required done@5", to, dc, ec);
      end
      checks++;
      if (addr_map[2*RW +: RW] !== r || addr_map !== exp_map()) begin
         failures++;
         $display("FAIL same_cycle_map: slot2=%h required %h", addr_map[2*RW +: RW], r);
      end
      $display("test_same_cycle_write: done@%0d", dc);
   endtask

   task automatic test_ready_during_check();
      int low, code, bad, guard;
      rule_t r;
      guard = 0;
      while (commit_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      model_result(code, bad);
      commit_valid = 1'b1;
      @(posedge clk); #1;
      commit_valid = 1'b0;
      model_apply(code);
      r = mk_rule(0, 32'h0000, 32'h0F00);
      cfg_valid = 1'b1; cfg_sel = 2'd0; cfg_rule = r;
      low = 0;
      while (cfg_ready !== 1'b1 && low < 50) begin
         low++;
         @(posedge clk); #1;
      end
      checks++;
      if (low != ((code == 0) ? NR + 1 : bad + 2)) begin
         failures++;
         $display("FAIL ready_low_cycles: got %0d required %0d", low, (code == 0) ? NR + 1 : bad + 2);
      end
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      shadow_m[0] = r;
      $display("test_ready_during_check: write held off %0d cycles", low);
   endtask

   task automatic test_back_to_back();
      int dc1, ec1, pc1, wt1, dc2, ec2, pc2, wt2; bit e1, e2, t1, t2;
      run_commit(1'b0, 2'd0, '0, dc1, ec1, pc1, e1, wt1, t1);
      model_apply(0);
      run_commit(1'b0, 2'd0, '0, dc2, ec2, pc2, e2, wt2, t2);
      checks++;
      if (t1 || t2 || dc1 != 5 || dc2 != 5 || wt2 != 0 || pc2 != 1) begin
         failures++;
         $display("FAIL back_to_back: done@%0d,%0d wait2=%0d pulses2=%0d required done@5,5 wait2=0 pulses2=1",
                  dc1, dc2, wt2, pc2);
      end
      $display("test_back_to_back: done@%0d then done@%0d", dc1, dc2);
   endtask

   task automatic test_random();
      int dc, ec, pc, wt, code, bad, nw; bit early, to, same;
      rule_t r;
      logic [1:0] s;
      for (int it = 0; it < 30; it++) begin
         nw = $urandom_range(1, 4);
         for (int w = 0; w < nw; w++) begin
            s = 2'($urandom_range(0, NR - 1));
            write_rule(s, rand_rule(int'(s)));
         end
         same = 1'($urandom_range(0, 1));
         s = 2'($urandom_range(0, NR - 1));
         r = rand_rule(int'(s));
         run_commit(same, s, r, dc, ec, pc, early, wt, to);
         model_result(code, bad);
         model_apply(code);
         checks++;
         if (to || pc != 1 || early ||
             (code == 0 && (dc != NR + 1 || ec != -1)) ||
             (code != 0 && (ec != bad + 2 || dc != -1))) begin
            failures++;
            $display("FAIL rand_timing[%0d]: to=%0b done@%0d err@%0d pulses=%0d early=%0b required code=%0d bad=%0d",
                     it, to, dc, ec, pc, early, code, bad);
         end
         checks++;
         if (err_code !== 2'(code) || err_rule !== 2'(bad)) begin
            failures++;
            $display("FAIL rand_code[%0d]: code=%0d rule=%0d required code=%0d rule=%0d",
                     it, err_code, err_rule, code, bad);
         end
         checks++;
         if (addr_map !== exp_map() || map_valid !== map_valid_m) begin
            failures++;
            $display("FAIL rand_map[%0d]: map=%h valid=%b required map=%h valid=%b",
                     it, addr_map, map_valid, exp_map(), map_valid_m);
         end
         $display("rand[%0d]: writes=%0d same_cycle=%0b code=%0d rule=%0d done@%0d err@%0d",
                  it, nw, same, code, bad, dc, ec);
      end
   endtask

   task automatic test_reset_mid_check();
      int guard, pulses, dc, ec, pc, wt; bit early, to;
      guard = 0;
      while (commit_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
      commit_valid = 1'b1;
      @(posedge clk); #1;
      commit_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (addr_map !== '0 || map_valid !== 1'b0) begin
         failures++;
         $display("FAIL midreset_map: map=%h valid=%b required 0", addr_map, map_valid);
      end
      checks++;
      if ({cfg_ready, commit_ready, commit_done, commit_err, err_code, err_rule} !== 8'd0) begin
         failures++;
         $display("FAIL midreset_ctrl: got %b required 0",
                  {cfg_ready, commit_ready, commit_done, commit_err, err_code, err_rule});
      end
      pulses = 0;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         if (commit_done === 1'b1 || commit_err === 1'b1) pulses++;
      end
      rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         if (commit_done === 1'b1 || commit_err === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || map_valid !== 1'b0 || addr_map !== '0) begin
         failures++;
         $display("FAIL midreset_after: pulses=%0d valid=%b map=%h required 0 pulses valid=0 map=0",
                  pulses, map_valid, addr_map);
      end
      // The shadow map was cleared, so rule 0 is now [0,0).
      run_commit(1'b0, 2'd0, '0, dc, ec, pc, early, wt, to);
      checks++;
      if (to || ec != 2 || err_code !== 2'd1 || err_rule !== 2'd0) begin
         failures++;
         $display("FAIL midreset_shadow: err@%0d code=%0d rule=%0d required err@2 code=1 rule=0",
                  ec, err_code, err_rule);
      end
      $display("test_reset_mid_check: post-reset commit code=%0d rule=%0d", err_code, err_rule);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_disjoint();
      test_bad_idx();
      test_bad_range();
      test_overlap();
      test_same_cycle_write();
      test_ready_during_check();
      test_back_to_back();
      test_random();
      test_reset_mid_check();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
      $fatal(1, "timeout");
   end

endmodule
